// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: opcodes and operand-mux selects.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SHL   = 4'd5;
    localparam logic [3:0] ALU_SHR   = 4'd6;
    localparam logic [3:0] ALU_SAR   = 4'd7;
    localparam logic [3:0] ALU_MOVB  = 4'd8;
    localparam logic [3:0] ALU_NOTB  = 4'd9;
    localparam logic [3:0] ALU_SLT   = 4'd10;
    localparam logic [3:0] ALU_SLTU  = 4'd11;
    localparam logic [3:0] ALU_EQ    = 4'd12;
    localparam logic [3:0] ALU_NE    = 4'd13;
    localparam logic [3:0] ALU_ANDN  = 4'd14;
    localparam logic [3:0] ALU_MOVHI = 4'd15;

    localparam logic       A_SEL_REG     = 1'b0;
    localparam logic       A_SEL_PCPLUS1 = 1'b1;

    localparam logic [1:0] B_SEL_REG   = 2'd0;
    localparam logic [1:0] B_SEL_IMM16 = 2'd1;
    localparam logic [1:0] B_SEL_IMM22 = 2'd2;
    localparam logic [1:0] B_SEL_ZERO  = 2'd3;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-operation ALU; shifts use only b[4:0].
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [4:0]       shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        res = 'x;
        case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_SHL:   res = a << shamt;
            ALU_SHR:   res = a >> shamt;
            ALU_SAR:   res = $unsigned(a_s >>> shamt);
            ALU_MOVB:  res = b;
            ALU_NOTB:  res = ~b;
            ALU_SLT:   res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_EQ:    res = {{(WIDTH-1){1'b0}}, (a == b)};
            ALU_NE:    res = {{(WIDTH-1){1'b0}}, (a != b)};
            ALU_ANDN:  res = a & ~b;
            ALU_MOVHI: res = b << 16;
            default:   res = 'x;
        endcase
    end

endmodule

// File: rtl/mux2_w.sv
// Generic width-parameterised 2:1 mux; an unknown select propagates X.
module mux2_w #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            1'b0:    y = d0;
            1'b1:    y = d1;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux4_w.sv
// Generic width-parameterised 4:1 mux, shared with the write-back path.
module mux4_w #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/alu_operand_datapath.sv
// Execute-stage slice: A/B operand muxes feeding the ALU, with a registered
// copy of the result and zero flag for pipelined consumers.
module alu_operand_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PCW   = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic             a_sel,
    input  logic [1:0]       b_sel,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [PCW-1:0]   pc_plus1,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] imm16_s,
    input  logic [WIDTH-1:0] imm22_s,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] pc_ext;

    assign pc_ext = {{(WIDTH-PCW){1'b0}}, pc_plus1};

    mux2_w #(.WIDTH(WIDTH)) u_a_mux (
        .sel (a_sel),
        .d0  (reg_a),
        .d1  (pc_ext),
        .y   (a_out)
    );

    mux4_w #(.WIDTH(WIDTH)) u_b_mux (
        .sel (b_sel),
        .d0  (reg_b),
        .d1  (imm16_s),
        .d2  (imm22_s),
        .d3  ({WIDTH{1'b0}}),
        .y   (b_out)
    );

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op  (op),
        .a   (a_out),
        .b   (b_out),
        .res (result)
    );

    assign zero = (result == '0);

    // Registered copy: reset dominates the load enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (en) begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_alu_operand_datapath.sv
// Self-checking bench: directed vector table, random ops against a reference
// model, and a hand-written register/enable/reset sequence.
module tb_alu_operand_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic [31:0] reg_a;
    logic [29:0] pc_plus1;
    logic [31:0] reg_b;
    logic [31:0] imm16_s;
    logic [31:0] imm22_s;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_operand_datapath #(.WIDTH(32), .PCW(30)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .op       (op),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .reg_a    (reg_a),
        .pc_plus1 (pc_plus1),
        .reg_b    (reg_b),
        .imm16_s  (imm16_s),
        .imm22_s  (imm22_s),
        .a_out    (a_out),
        .b_out    (b_out),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    typedef struct {
        logic [3:0]  op;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [31:0] reg_a;
        logic [29:0] pc;
        logic [31:0] reg_b;
        logic [31:0] imm16;
        logic [31:0] imm22;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mkv(input logic [3:0] o, input logic as, input logic [1:0] bs,
                                 input logic [31:0] ra, input logic [29:0] pc,
                                 input logic [31:0] rb, input logic [31:0] i16,
                                 input logic [31:0] i22, input logic [31:0] er, input logic ez);
        vec_t v;
        v.op = o; v.a_sel = as; v.b_sel = bs; v.reg_a = ra; v.pc = pc;
        v.reg_b = rb; v.imm16 = i16; v.imm22 = i22; v.exp_res = er; v.exp_zero = ez;
        return v;
    endfunction

    // Reference model built from arithmetic definitions of each operation.
    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned wide;
        logic [31:0] s;
        logic [31:0] pow2;
        s = 32'(b % 32);
        pow2 = 32'd1 << s;
        case (o)
            4'd0: begin wide = longint'(a) + longint'(b); return wide[31:0]; end
            4'd1: begin wide = longint'(a) + 64'h1_0000_0000 - longint'(b); return wide[31:0]; end
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: begin wide = longint'(a) * longint'(pow2); return wide[31:0]; end
            4'd6: return a / pow2;
            4'd7: return (a / pow2) | (a[31] ? ~(32'hFFFF_FFFF / pow2) : 32'h0);
            4'd8: return b;
            4'd9: return 32'hFFFF_FFFF - b;
            4'd10: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return (a == b) ? 32'd1 : 32'd0;
            4'd13: return (a == b) ? 32'd0 : 32'd1;
            4'd14: return a & (32'hFFFF_FFFF - b);
            default: begin wide = longint'(b) * 64'd65536; return wide[31:0]; end
        endcase
    endfunction

    initial begin
        logic [31:0] ea, eb, er;
        logic [31:0] exp_q;
        logic        exp_zq;

        rst = 1'b1; en = 1'b0; op = 4'd0; a_sel = 1'b0; b_sel = 2'd0;
        reg_a = '0; pc_plus1 = '0; reg_b = '0; imm16_s = '0; imm22_s = '0;

        @(posedge clk); #1;
        check("reset_result_q", result_q, 32'h0);
        check("reset_zero_q", {31'b0, zero_q}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back(mkv(4'd0, 1, 2, 0, 30'h10, 0, 0, 32'hFFFFFFFC, 32'h0000000C, 0));
        vecs.push_back(mkv(4'd1, 0, 0, 5, 0, 5, 0, 0, 32'h0, 1));
        vecs.push_back(mkv(4'd1, 0, 0, 5, 0, 6, 0, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mkv(4'd8, 0, 3, 9, 0, 32'h1234, 0, 0, 32'h0, 1));
        vecs.push_back(mkv(4'd8, 0, 1, 9, 0, 32'h1234, 32'hFFFF8000, 0, 32'hFFFF8000, 0));
        vecs.push_back(mkv(4'd5, 0, 0, 32'h80000001, 0, 33, 0, 0, 32'h00000002, 0));
        vecs.push_back(mkv(4'd6, 0, 0, 32'h80000001, 0, 33, 0, 0, 32'h40000000, 0));
        vecs.push_back(mkv(4'd7, 0, 0, 32'h80000001, 0, 33, 0, 0, 32'hC0000000, 0));
        vecs.push_back(mkv(4'd10, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h1, 0));
        vecs.push_back(mkv(4'd11, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0, 1));
        vecs.push_back(mkv(4'd12, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h0, 1));
        vecs.push_back(mkv(4'd13, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h1, 0));
        vecs.push_back(mkv(4'd5, 0, 0, 32'h5, 0, 32, 0, 0, 32'h5, 0));
        vecs.push_back(mkv(4'd9, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0));
        vecs.push_back(mkv(4'd15, 0, 0, 0, 0, 32'h0000ABCD, 0, 0, 32'hABCD0000, 0));
        vecs.push_back(mkv(4'd14, 0, 0, 32'hF0F0FFFF, 0, 32'h0F0F00FF, 0, 0, 32'hF0F0FF00, 0));
        vecs.push_back(mkv(4'd2, 0, 0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 0, 32'h0F000F00, 0));
        vecs.push_back(mkv(4'd3, 0, 0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 0, 32'hFFF0FFF0, 0));
        vecs.push_back(mkv(4'd4, 0, 0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 0, 32'hF0F0F0F0, 0));
        vecs.push_back(mkv(4'd0, 1, 3, 32'h1234, 30'h3FFFFFFF, 0, 0, 0, 32'h3FFFFFFF, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            op = vecs[i].op; a_sel = vecs[i].a_sel; b_sel = vecs[i].b_sel;
            reg_a = vecs[i].reg_a; pc_plus1 = vecs[i].pc; reg_b = vecs[i].reg_b;
            imm16_s = vecs[i].imm16; imm22_s = vecs[i].imm22;
            #1;
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
        end

        // Random operations with random enable; registered copy tracked alongside.
        exp_q = result_q;
        exp_zq = zero_q;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a_sel = 1'($urandom_range(0, 1));
            b_sel = 2'($urandom_range(0, 3));
            reg_a = $urandom;
            pc_plus1 = 30'($urandom);
            reg_b = ($urandom_range(0, 3) == 0) ? reg_a : $urandom;
            imm16_s = {{16{reg_b[7]}}, 16'($urandom)};
            imm16_s[31:16] = {16{imm16_s[15]}};
            imm22_s = 32'($urandom);
            imm22_s[31:22] = {10{imm22_s[21]}};
            en = 1'($urandom_range(0, 1));
            ea = a_sel ? {2'b00, pc_plus1} : reg_a;
            case (b_sel)
                2'd0: eb = reg_b;
                2'd1: eb = imm16_s;
                2'd2: eb = imm22_s;
                default: eb = 32'h0;
            endcase
            er = ref_alu(op, ea, eb);
            #1;
            check($sformatf("rnd%0d_a_out", i), a_out, ea);
            check($sformatf("rnd%0d_b_out", i), b_out, eb);
            check($sformatf("rnd%0d_op%0d_result", i, op), result, er);
            check($sformatf("rnd%0d_zero", i), {31'b0, zero}, {31'b0, (er == 0)});
            if (en) begin
                exp_q = er;
                exp_zq = (er == 0);
            end
            @(posedge clk); #1;
            check($sformatf("rnd%0d_result_q", i), result_q, exp_q);
            check($sformatf("rnd%0d_zero_q", i), {31'b0, zero_q}, {31'b0, exp_zq});
        end

        // Load, hold with en low, then reset overriding en.
        @(negedge clk);
        op = 4'd0; a_sel = 1'b0; b_sel = 2'd3; reg_a = 32'd7; en = 1'b1;
        @(posedge clk); #1;
        check("seq_load_result_q", result_q, 32'd7);
        check("seq_load_zero_q", {31'b0, zero_q}, 32'h0);
        @(negedge clk);
        en = 1'b0; reg_a = 32'd9;
        @(posedge clk); #1;
        check("seq_hold_comb_result", result, 32'd9);
        check("seq_hold_result_q", result_q, 32'd7);
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        check("seq_rst_result_q", result_q, 32'h0);
        check("seq_rst_zero_q", {31'b0, zero_q}, 32'h1);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_operand_datapath.md
Name: alu_operand_datapath

Overview:
- Execute-stage datapath slice of the 32-bit CPU: a 2:1 A-operand mux, a 4:1 B-operand mux and a 4-bit-opcode ALU.
- Result is available combinationally for same-cycle use (branch target, load/store address, register write-back).
- A registered copy with a zero flag is provided for pipelined consumers.
- Instantiated by the core's control unit, which drives the select and opcode lines.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- PCW, 30, width of the word-addressed PC+1 input; zero-extended to WIDTH.

Ports:
- clk  in  1  clock; only result_q/zero_q are sequential.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  load enable for result_q/zero_q.
- op  in  4  ALU operation code.
- a_sel  in  1  A mux: 0=reg_a, 1=pc_plus1 zero-extended.
- b_sel  in  2  B mux: 0=reg_b, 1=imm16_s, 2=imm22_s, 3=constant 0.
- reg_a  in  WIDTH  register-file port A.
- pc_plus1  in  PCW  PC+1 (word address).
- reg_b  in  WIDTH  register-file port B.
- imm16_s  in  WIDTH  sign-extended 16-bit immediate.
- imm22_s  in  WIDTH  sign-extended 22-bit immediate.
- a_out  out  WIDTH  selected A operand.
- b_out  out  WIDTH  selected B operand.
- result  out  WIDTH  combinational ALU result.
- zero  out  1  result == 0, combinational.
- result_q  out  WIDTH  registered result.
- zero_q  out  1  registered zero flag.

Behaviour:
- Muxes and ALU are purely combinational, with zero latency from any input to a_out/b_out/result/zero.
- Select values are fully decoded. An X or Z on a select drives X on the output; it must never silently pick an input.
- A operand is {(WIDTH-PCW)'b0, pc_plus1} when a_sel=1.
- Opcodes (a=A operand, b=B operand):
  - 0 ADD a+b, modulo 2^WIDTH. This is the opcode used for branch targets and address generation.
  - 1 SUB a-b, modulo 2^WIDTH.
  - 2 AND; 3 OR; 4 XOR.
  - 5 SHL a<<b[4:0]; 6 SHR logical a>>b[4:0]; 7 SAR arithmetic a>>>b[4:0].
  - 8 MOVB b; 9 NOTB ~b.
  - 10 SLT: 1 if signed a<b, else 0. 11 SLTU: unsigned compare, same encoding.
  - 12 EQ: 1 if a==b, else 0. 13 NE: 1 if a!=b, else 0.
  - 14 ANDN a&~b; 15 MOVHI b<<16.
- Shift amount uses only b[4:0]; upper bits are ignored, so a shift of 32 acts as a shift of 0.
- No carry or overflow outputs. ADD/SUB overflow wraps.
- Sequential:
  - rst=1 at posedge: result_q=0, zero_q=1, regardless of en.
  - Otherwise, if en=1: result_q<=result, zero_q<=zero.
  - If en=0: hold.
  - Reset dominates en when both are asserted.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_ADD..ALU_MOVHI (4-bit).
  - A-select constants A_SEL_REG=0, A_SEL_PCPLUS1=1.
  - B-select constants B_SEL_REG=0, B_SEL_IMM16=1, B_SEL_IMM22=2, B_SEL_ZERO=3.
- Sub-modules: generic mux2_w and mux4_w, both parameterised by width; mux4_w is reused by the register write-back mux.
- The ALU core is a natural single sub-module, alu_core, with inputs op, a, b and output res.

Test Plan:
- ADD via PC: a_sel=1, pc_plus1=30'h00000010, b_sel=2, imm22_s=32'hFFFFFFFC, op=0 -> result=32'h0000000C, zero=0.
- SUB wrap and zero: a_sel=0, reg_a=5, b_sel=0, reg_b=5, op=1 -> result=0, zero=1. Then reg_b=6 -> result=32'hFFFFFFFF.
- B mux constant: b_sel=3, op=8 -> result=0 for any reg_b. Then b_sel=1, imm16_s=32'hFFFF8000, op=8 -> result=32'hFFFF8000.
- Shifts: reg_a=32'h80000001, b=33 (b[4:0]=1):
  - op=5 -> 32'h00000002.
  - op=6 -> 32'h40000000.
  - op=7 -> 32'hC0000000.
- Compares: reg_a=32'hFFFFFFFF, reg_b=1:
  - op=10 -> 1.
  - op=11 -> 0.
  - op=12 -> 0.
  - op=13 -> 1.
- Register/reset: drive result=7 with en=1, clock -> result_q=7, zero_q=0. Then en=0 with result changed -> holds 7. Then rst=1 with en=1 -> result_q=0, zero_q=1 after the same edge.
